div_unit: RTL and testbench

DIV_UNIT -- requirements
Module: div_unit

---
 rtl/div_unit_pkg.sv | 29 ++
 rtl/div_unit_if.sv | 27 ++
 rtl/div_step.sv | 20 ++
 rtl/div_unit.sv | 137 +++++++++++++
 tb/tb_div_unit.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/div_unit_pkg.sv
// Shared definitions for the divider: operation codes, FSM encodings, iteration count.
// Also holds the per-iteration state record and a conditional absolute-value helper.
package div_unit_pkg;

  localparam int XLEN  = 32;
  localparam int AW    = 5;
  localparam int ITERS = 32;
  localparam int CNT_W = 6;

  localparam logic [1:0] FUNC_DIV  = 2'b00;
  localparam logic [1:0] FUNC_DIVU = 2'b01;
  localparam logic [1:0] FUNC_REM  = 2'b10;
  localparam logic [1:0] FUNC_REMU = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;
  localparam logic [1:0] ST_FIN  = 2'd3;

  typedef struct packed {
    logic [XLEN:0]   rem;
    logic [XLEN-1:0] quo;
  } step_t;

  function automatic logic [XLEN-1:0] abs_if(input logic [XLEN-1:0] v, input logic sgn);
    return (sgn && v[XLEN-1]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/div_unit_if.sv
// Request/response bundle between the issue stage and the divider.
// Master drives the request and flush; slave returns result, address and status.
interface div_unit_if;
  import div_unit_pkg::*;

  logic            start;
  logic [1:0]      func;
  logic [XLEN-1:0] op1;
  logic [XLEN-1:0] op2;
  logic [AW-1:0]   dest;
  logic            kill;
  logic [XLEN-1:0] result;
  logic [AW-1:0]   result_addr;
  logic            busy;
  logic            done;

  modport master (
    output start, func, op1, op2, dest, kill,
    input  result, result_addr, busy, done
  );

  modport slave (
    input  start, func, op1, op2, dest, kill,
    output result, result_addr, busy, done
  );

endinterface

// File: rtl/div_step.sv
// One restoring shift-subtract iteration: shift the next dividend bit into the partial
// remainder, subtract the divisor, keep the difference only if it did not borrow.
module div_step
  import div_unit_pkg::*;
(
  input  step_t           cur_i,
  input  logic [XLEN-1:0] dvs_i,
  output step_t           nxt_o
);

  logic          borrow;
  logic [XLEN:0] diff;

  always_comb begin
    {borrow, diff} = {cur_i.rem, cur_i.quo[XLEN-1]} - {2'b00, dvs_i};
    nxt_o.rem      = borrow ? {cur_i.rem[XLEN-1:0], cur_i.quo[XLEN-1]} : diff;
    nxt_o.quo      = {cur_i.quo[XLEN-2:0], ~borrow};
  end

endmodule

// File: rtl/div_unit.sv
// Iterative 32-bit RISC-V divider: DIV/DIVU/REM/REMU, 33-cycle latency, one bit per cycle.
// Divide-by-zero and signed overflow skip the iteration loop and finish one cycle after start.
module div_unit
  import div_unit_pkg::*;
(
  input logic       clk,
  input logic       rst_n,
  div_unit_if.slave bus
);

  logic [1:0]       state_q, state_d;
  logic             rem_sel_q, rem_sel_d;
  logic             neg_q, neg_d;
  logic             byp_q, byp_d;
  logic [AW-1:0]    dest_q, dest_d;
  logic [XLEN-1:0]  quo_q, quo_d;
  logic [XLEN-1:0]  dvs_q, dvs_d;
  logic [XLEN:0]    rem_q, rem_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  result_q, result_d;
  logic [AW-1:0]    raddr_q, raddr_d;

  logic            accept;
  logic            in_signed, in_rem, div_zero, ovf;
  logic [XLEN-1:0] special;
  logic [XLEN-1:0] mag;
  step_t           step_cur, step_nxt;

  assign step_cur.rem = rem_q;
  assign step_cur.quo = quo_q;

  div_step u_step (
    .cur_i (step_cur),
    .dvs_i (dvs_q),
    .nxt_o (step_nxt)
  );

  assign accept    = bus.start && (state_q == ST_IDLE || state_q == ST_FIN);
  assign in_signed = ~bus.func[0];
  assign in_rem    = bus.func[1];
  assign div_zero  = (bus.op2 == '0);
  assign ovf       = in_signed && (bus.op1 == 32'h8000_0000) && (bus.op2 == 32'hFFFF_FFFF);
  assign special   = div_zero ? (in_rem ? bus.op1 : 32'hFFFF_FFFF)
                              : (in_rem ? 32'h0000_0000 : 32'h8000_0000);
  assign mag       = rem_sel_q ? rem_q[XLEN-1:0] : quo_q;

  always_comb begin
    state_d   = state_q;
    rem_sel_d = rem_sel_q;
    neg_d     = neg_q;
    byp_d     = byp_q;
    dest_d    = dest_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    rem_d     = rem_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    raddr_d   = raddr_q;

    case (state_q)
      ST_IDLE, ST_FIN: begin
        state_d = ST_IDLE;
        if (accept) begin
          rem_sel_d = in_rem;
          dest_d    = bus.dest;
          cnt_d     = '0;
          rem_d     = '0;
          dvs_d     = abs_if(bus.op2, in_signed);
          neg_d     = in_signed && (in_rem ? bus.op1[XLEN-1]
                                           : (bus.op1[XLEN-1] ^ bus.op2[XLEN-1]));
          // Special cases park their final answer in the quotient register.
          if (div_zero || ovf) begin
            byp_d   = 1'b1;
            quo_d   = special;
            state_d = ST_FIX;
          end else begin
            byp_d   = 1'b0;
            quo_d   = abs_if(bus.op1, in_signed);
            state_d = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        quo_d = step_nxt.quo;
        rem_d = step_nxt.rem;
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == CNT_W'(ITERS - 1)) begin
          state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        result_d = byp_q ? quo_q : (neg_q ? (~mag + 32'd1) : mag);
        raddr_d  = dest_q;
        state_d  = ST_FIN;
      end
      default: state_d = ST_IDLE;
    endcase

    if (bus.kill) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      rem_sel_q <= 1'b0;
      neg_q     <= 1'b0;
      byp_q     <= 1'b0;
      dest_q    <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
      raddr_q   <= '0;
    end else begin
      state_q   <= state_d;
      rem_sel_q <= rem_sel_d;
      neg_q     <= neg_d;
      byp_q     <= byp_d;
      dest_q    <= dest_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      rem_q     <= rem_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
      raddr_q   <= raddr_d;
    end
  end

  assign bus.result      = result_q;
  assign bus.result_addr = raddr_q;
  assign bus.busy        = (state_q == ST_CALC) || (state_q == ST_FIX);
  assign bus.done        = (state_q == ST_FIN);

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: directed operations push expected results,
// a negedge monitor pops and compares result, address and latency on each DONE.
module tb_div_unit;
  import div_unit_pkg::*;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  addr;
    time         t0;
    int          lat;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  exp_t exp_q[$];

  div_unit_if bus();

  div_unit u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done result=%h addr=%0d", bus.result, bus.result_addr);
      end else begin
        exp_t e;
        int   lat_got;
        e       = exp_q.pop_front();
        lat_got = int'(($time - e.t0 - 5) / 10);
        check("result", bus.result, e.res);
        check("result_addr", {27'd0, bus.result_addr}, {27'd0, e.addr});
        check("latency", lat_got, e.lat);
      end
    end
  end

  // Drives a request for one cycle; caller must be positioned between posedge and negedge-or-later.
  task automatic issue(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] d, input logic [31:0] res, input int lat,
                       input bit push);
    exp_t e;
    bus.start = 1'b1;
    bus.func  = f;
    bus.op1   = a;
    bus.op2   = b;
    bus.dest  = d;
    @(posedge clk);
    if (push) begin
      e.res  = res;
      e.addr = d;
      e.t0   = $time;
      e.lat  = lat;
      exp_q.push_back(e);
    end
    #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.done) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL %s_timeout done=0 want=1", name);
    end else if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_busy_at_done got=%b want=0", name, bus.busy);
    end
  endtask

  task automatic run_op(input string name, input logic [1:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] d,
                        input logic [31:0] res, input int lat);
    issue(f, a, b, d, res, lat, 1'b1);
    @(negedge clk);
    check({name, "_busy"}, {31'd0, bus.busy}, 32'd1);
    if (lat > 1) wait_done(name);
    else begin
      check({name, "_done"}, {31'd0, bus.done}, 32'd0);
      wait_done(name);
    end
    @(negedge clk);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.kill  = 1'b0;
    bus.func  = FUNC_DIV;
    bus.op1   = '0;
    bus.op2   = '0;
    bus.dest  = '0;
    #1;
    check("rst_result", bus.result, 32'd0);
    check("rst_addr", {27'd0, bus.result_addr}, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Signed division and remainder with mixed signs.
    run_op("div_20_m3", FUNC_DIV, 32'd20, 32'hFFFF_FFFD, 5'd1, 32'hFFFF_FFFA, 33);
    run_op("rem_20_m3", FUNC_REM, 32'd20, 32'hFFFF_FFFD, 5'd2, 32'd2, 33);
    run_op("rem_m20_3", FUNC_REM, 32'hFFFF_FFEC, 32'd3, 5'd3, 32'hFFFF_FFFE, 33);

    // Divide-by-zero and signed overflow shortcuts.
    run_op("divu_by0", FUNC_DIVU, 32'd7, 32'd0, 5'd8, 32'hFFFF_FFFF, 1);
    run_op("rem_by0", FUNC_REM, 32'd7, 32'd0, 5'd9, 32'd7, 1);
    run_op("div_ovf", FUNC_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'h8000_0000, 1);
    run_op("rem_ovf", FUNC_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'd0, 1);

    // Flush mid-calculation, then the same operation to completion.
    issue(FUNC_DIVU, 32'd100, 32'd7, 5'd5, 32'd0, 0, 1'b0);
    repeat (9) @(negedge clk);
    bus.kill = 1'b1;
    @(posedge clk);
    #1;
    bus.kill = 1'b0;
    @(negedge clk);
    check("kill_busy", {31'd0, bus.busy}, 32'd0);
    check("kill_done", {31'd0, bus.done}, 32'd0);

    // Flush wins over a simultaneous start in IDLE.
    bus.kill = 1'b1;
    issue(FUNC_DIVU, 32'd100, 32'd7, 5'd5, 32'd0, 0, 1'b0);
    bus.kill = 1'b0;
    @(negedge clk);
    check("kill_start_busy", {31'd0, bus.busy}, 32'd0);

    run_op("divu_100_7", FUNC_DIVU, 32'd100, 32'd7, 5'd5, 32'd14, 33);

    // Back-to-back: second start lands in the FIN cycle of the first.
    issue(FUNC_DIVU, 32'hFFFF_FFFF, 32'd2, 5'd3, 32'h7FFF_FFFF, 33, 1'b1);
    wait_done("b2b_first");
    issue(FUNC_REMU, 32'hFFFF_FFFF, 32'd2, 5'd4, 32'd1, 33, 1'b1);
    @(negedge clk);
    check("b2b_no_gap_busy", {31'd0, bus.busy}, 32'd1);
    repeat (4) @(negedge clk);
    issue(FUNC_DIV, 32'd1, 32'd1, 5'd7, 32'd0, 0, 1'b0);
    wait_done("b2b_second");
    repeat (3) @(negedge clk);
    check("hold_result", bus.result, 32'd1);
    check("hold_addr", {27'd0, bus.result_addr}, 32'd4);

    // Asynchronous reset in the middle of CALC.
    issue(FUNC_DIV, 32'd9, 32'd3, 5'd6, 32'd0, 0, 1'b0);
    repeat (5) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_result", bus.result, 32'd0);
    check("arst_addr", {27'd0, bus.result_addr}, 32'd0);
    check("arst_busy", {31'd0, bus.busy}, 32'd0);
    check("arst_done", {31'd0, bus.done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op("div_9_3", FUNC_DIV, 32'd9, 32'd3, 5'd6, 32'd3, 33);

    repeat (5) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
